// File: rtl/bcm_pkg.sv
// bcm_pkg: shared width helpers for the baseline-subtract lanes
package bcm_pkg;
  function automatic int adc_shift(input int sample_width, input int adc_width);
    return sample_width - adc_width;
  endfunction
  function automatic int idx_width(input int samples_per_clock);
    return samples_per_clock > 1 ? $clog2(samples_per_clock) : 0;
  endfunction
  function automatic int acc_width(input int adc_width, input int avg_shift, input int samples_per_clock);
    return adc_width + avg_shift + idx_width(samples_per_clock);
  endfunction
endpackage

// File: rtl/bcm_baseline_subtract_if.sv
// bcm_baseline_subtract_if: beat bus (axiValid/axiData/baselineGate/bypass in, outValid/outData/baselineValid out)
interface bcm_baseline_subtract_if #(
  parameter int CHANNEL_COUNT = 1,
  parameter int AXI_SAMPLES_PER_CLOCK = 1,
  parameter int AXI_SAMPLE_WIDTH = 16
);
  localparam int DW = CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK * AXI_SAMPLE_WIDTH;
  logic [CHANNEL_COUNT-1:0] axiValid;
  logic [DW-1:0] axiData;
  logic baselineGate;
  logic bypass;
  logic [CHANNEL_COUNT-1:0] outValid;
  logic [DW-1:0] outData;
  logic [CHANNEL_COUNT-1:0] baselineValid;
  modport master(output axiValid, axiData, baselineGate, bypass, input outValid, outData, baselineValid);
  modport slave(input axiValid, axiData, baselineGate, bypass, output outValid, outData, baselineValid);
endinterface

// File: rtl/bcm_baseline_lane.sv
// bcm_baseline_lane: one channel -- windowed baseline estimate and 2-stage subtract/saturate (clk, rst, valid/data in, out_valid/out_data/baseline_valid out)
module bcm_baseline_lane import bcm_pkg::*; #(
  parameter int SPC = 1,
  parameter int SW = 16,
  parameter int AW = 14,
  parameter int AVG = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic [SPC*SW-1:0] data,
  input  logic gate,
  input  logic bypass,
  output logic out_valid,
  output logic [SPC*SW-1:0] out_data,
  output logic baseline_valid
);
  localparam int SH = adc_shift(SW, AW);
  localparam int IW = idx_width(SPC);
  localparam int ACCW = acc_width(AW, AVG, SPC);
  localparam logic [AVG:0] LAST = (AVG+1)'((1 << AVG) - 1);
  logic signed [ACCW-1:0] acc, beat_sum, acc_next, avg;
  logic [AVG:0] cnt;
  logic [AW-1:0] baseline, base1;
  logic [AW-1:0] smp [SPC];
  logic [AW-1:0] smp1 [SPC];
  logic v1, byp1;
  logic [AW:0] diff;
  logic [AW-1:0] sat_v;
  logic [SPC*SW-1:0] res;
  logic unused_data;
  assign unused_data = ^data;
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < SPC; i++) begin
      smp[i] = data[i*SW+SH +: AW];
      beat_sum = beat_sum + ACCW'($signed(smp[i]));
    end
    acc_next = acc + beat_sum;
    avg = acc_next >>> (AVG + IW);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      baseline <= '0;
      baseline_valid <= 1'b0;
    end else if (gate && valid) begin
      acc <= cnt == LAST ? '0 : acc_next;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      if (cnt == LAST) begin
        baseline <= avg[AW-1:0];
        baseline_valid <= 1'b1;
      end
    end else if (!gate) begin
      acc <= '0;
      cnt <= '0;
    end
  end
  // Stage 1 samples the baseline register before any same-cycle latch, so the completing beat still sees the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      byp1 <= 1'b0;
      base1 <= '0;
      for (int i = 0; i < SPC; i++) smp1[i] <= '0;
    end else begin
      v1 <= valid;
      byp1 <= bypass;
      base1 <= baseline;
      for (int i = 0; i < SPC; i++) smp1[i] <= smp[i];
    end
  end
  always_comb begin
    res = '0;
    diff = '0;
    sat_v = '0;
    for (int i = 0; i < SPC; i++) begin
      diff = {smp1[i][AW-1], smp1[i]} - {base1[AW-1], base1};
      sat_v = diff[AW] != diff[AW-1] ? {diff[AW], {(AW-1){~diff[AW]}}} : diff[AW-1:0];
      res[i*SW +: SW] = SW'(byp1 ? smp1[i] : sat_v) << SH;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= v1;
      if (v1) out_data <= res;
    end
  end
endmodule

// File: rtl/bcm_baseline_subtract.sv
// bcm_baseline_subtract: per-channel baseline estimation and subtraction (adcClk, adcReset, axiValid/axiData/baselineGate/bypass in, outValid/outData/baselineValid out)
module bcm_baseline_subtract import bcm_pkg::*; #(
  parameter int CHANNEL_COUNT = -1,
  parameter int AXI_SAMPLES_PER_CLOCK = -1,
  parameter int AXI_SAMPLE_WIDTH = -1,
  parameter int ADC_WIDTH = -1,
  parameter int AVG_SHIFT = 4
) (
  input  logic adcClk,
  input  logic adcReset,
  input  logic [CHANNEL_COUNT-1:0] axiValid,
  input  logic [CHANNEL_COUNT*AXI_SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] axiData,
  input  logic baselineGate,
  input  logic bypass,
  output logic [CHANNEL_COUNT-1:0] outValid,
  output logic [CHANNEL_COUNT*AXI_SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] outData,
  output logic [CHANNEL_COUNT-1:0] baselineValid
);
  localparam int LW = AXI_SAMPLES_PER_CLOCK * AXI_SAMPLE_WIDTH;
  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_lane
    bcm_baseline_lane #(
      .SPC(AXI_SAMPLES_PER_CLOCK),
      .SW(AXI_SAMPLE_WIDTH),
      .AW(ADC_WIDTH),
      .AVG(AVG_SHIFT)
    ) u_lane (
      .clk(adcClk),
      .rst(adcReset),
      .valid(axiValid[c]),
      .data(axiData[c*LW +: LW]),
      .gate(baselineGate),
      .bypass(bypass),
      .out_valid(outValid[c]),
      .out_data(outData[c*LW +: LW]),
      .baseline_valid(baselineValid[c])
    );
  end
endmodule

// File: tb/tb_bcm_baseline_subtract.sv
// tb_bcm_baseline_subtract: directed table, reset sequence and random stimulus against a window-average model
module tb_bcm_baseline_subtract;
  localparam int CC = 2, SPC = 2, SW = 16, AW = 14, AVG = 2, NS = CC * SPC;
  typedef struct {
    bit gate, byp, vld;
    int s;
    bit eov;
    int eout;
    bit ebv;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bcm_baseline_subtract_if #(.CHANNEL_COUNT(CC), .AXI_SAMPLES_PER_CLOCK(SPC), .AXI_SAMPLE_WIDTH(SW)) bif();
  bcm_baseline_subtract #(
    .CHANNEL_COUNT(CC), .AXI_SAMPLES_PER_CLOCK(SPC), .AXI_SAMPLE_WIDTH(SW), .ADC_WIDTH(AW), .AVG_SHIFT(AVG)
  ) dut (
    .adcClk(clk),
    .adcReset(rst),
    .axiValid(bif.axiValid),
    .axiData(bif.axiData),
    .baselineGate(bif.baselineGate),
    .bypass(bif.bypass),
    .outValid(bif.outValid),
    .outData(bif.outData),
    .baselineValid(bif.baselineValid)
  );
  int checks = 0, errors = 0;
  int base[CC], sum[CC], n[CC];
  bit bv[CC], p_v[CC];
  int p_d[NS], hd[NS], smp[NS];
  vec_t tbl[$];
  function automatic int sat(int x);
    return x > 8191 ? 8191 : (x < -8192 ? -8192 : x);
  endfunction
  function automatic int fld(int v);
    return (v & 16'h3fff) << 2;
  endfunction
  function automatic int dut_field(int i);
    return int'(bif.outData[i*SW +: SW]);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < CC; c++) begin
      base[c] = 0; sum[c] = 0; n[c] = 0; bv[c] = 0; p_v[c] = 0;
    end
    for (int i = 0; i < NS; i++) begin
      p_d[i] = 0; hd[i] = 0;
    end
  endtask
  task automatic step(bit gate, bit byp, bit [CC-1:0] vld);
    int cur_d[NS];
    bit cur_v[CC];
    bif.baselineGate = gate;
    bif.bypass = byp;
    bif.axiValid = vld;
    for (int i = 0; i < NS; i++) bif.axiData[i*SW +: SW] = 16'(fld(smp[i]));
    for (int c = 0; c < CC; c++) begin
      cur_v[c] = vld[c];
      for (int j = 0; j < SPC; j++) cur_d[c*SPC+j] = byp ? smp[c*SPC+j] : sat(smp[c*SPC+j] - base[c]);
      if (gate && vld[c]) begin
        for (int j = 0; j < SPC; j++) sum[c] += smp[c*SPC+j];
        n[c]++;
        if (n[c] == (1 << AVG)) begin
          base[c] = sum[c] >>> (AVG + 1);
          bv[c] = 1;
          sum[c] = 0;
          n[c] = 0;
        end
      end else if (!gate) begin
        sum[c] = 0;
        n[c] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < CC; c++) begin
      if (p_v[c]) for (int j = 0; j < SPC; j++) hd[c*SPC+j] = p_d[c*SPC+j];
      chk($sformatf("model outValid ch%0d", c), int'(bif.outValid[c]), int'(p_v[c]));
      chk($sformatf("model baselineValid ch%0d", c), int'(bif.baselineValid[c]), int'(bv[c]));
      for (int j = 0; j < SPC; j++) chk($sformatf("model outData s%0d", c*SPC+j), dut_field(c*SPC+j), fld(hd[c*SPC+j]));
    end
    p_v = cur_v;
    p_d = cur_d;
  endtask
  task automatic add(bit g, bit b, bit v, int s, bit eov, int eout, bit ebv);
    tbl.push_back('{g, b, v, s, eov, eout, ebv});
  endtask
  initial begin
    bif.axiValid = '0;
    bif.axiData = '0;
    bif.baselineGate = 1'b0;
    bif.bypass = 1'b0;
    model_reset();
    add(0,0,1,  -20,0,    0,0); add(0,0,0,    0,1,  -20,0);
    add(1,0,1,  100,0,    0,0); add(1,0,1,  100,1,  100,0);
    add(1,0,1,  100,1,  100,0); add(1,0,1,  100,1,  100,1);
    add(0,0,1,  150,1,  100,1); add(0,0,0,    0,1,   50,1);
    add(1,1,1,  150,0,    0,1); add(1,1,1,  150,1,  150,1);
    add(1,0,1,  150,1,  150,1); add(1,0,1,  150,1,   50,1);
    add(0,0,0,    0,1,   50,1); add(0,0,1,  150,0,    0,1);
    add(0,0,0,    0,1,    0,1); add(1,0,1,  500,0,    0,1);
    add(1,0,1,  500,1,  350,1); add(1,0,1,  500,1,  350,1);
    add(0,0,1,  150,1,  350,1); add(0,0,0,    0,1,    0,1);
    add(1,0,1,  300,0,    0,1); add(1,0,1,  300,1,  150,1);
    add(1,0,1,  300,1,  150,1); add(1,0,1,  300,1,  150,1);
    add(0,0,1,  300,1,  150,1); add(0,0,0,    0,1,    0,1);
    add(1,0,1,-8000,0,    0,1); add(1,0,1,-8000,1,-8192,1);
    add(1,0,1,-8000,1,-8192,1); add(1,0,1,-8000,1,-8192,1);
    add(0,0,1, 8000,1,-8192,1); add(0,0,0,    0,1, 8191,1);
    add(1,0,1, 8000,0,    0,1); add(1,0,1, 8000,1, 8191,1);
    add(1,0,1, 8000,1, 8191,1); add(1,0,1, 8000,1, 8191,1);
    add(0,0,1,-8000,1, 8191,1); add(0,0,0,    0,1,-8192,1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset outValid", int'(bif.outValid), 0);
    chk("reset baselineValid", int'(bif.baselineValid), 0);
    chk("reset outData", int'(bif.outData == '0), 1);
    rst = 1'b0;
    foreach (tbl[r]) begin
      for (int i = 0; i < NS; i++) smp[i] = tbl[r].s;
      step(tbl[r].gate, tbl[r].byp, {CC{tbl[r].vld}});
      chk($sformatf("table r%0d outValid", r), int'(bif.outValid[0]), int'(tbl[r].eov));
      if (tbl[r].eov) chk($sformatf("table r%0d outData", r), dut_field(0), fld(tbl[r].eout));
      chk($sformatf("table r%0d baselineValid", r), int'(bif.baselineValid[0]), int'(tbl[r].ebv));
    end
    for (int i = 0; i < NS; i++) smp[i] = 50;
    step(1, 0, '1);
    step(1, 0, '1);
    rst = 1'b1;
    #1;
    chk("midreset outValid", int'(bif.outValid), 0);
    chk("midreset baselineValid", int'(bif.baselineValid), 0);
    chk("midreset outData", int'(bif.outData == '0), 1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(1, 0, '1);
    chk("postreset 3 beats baselineValid", int'(bif.baselineValid), 0);
    step(1, 0, '1);
    chk("postreset 4 beats baselineValid", int'(bif.baselineValid), 3);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NS; i++) smp[i] = int'($urandom_range(16383)) - 8192;
      step($urandom_range(3) != 0, $urandom_range(7) == 0, CC'($urandom_range(3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
